// File: rtl/alu_pkg.sv
// Shared opcode encoding, micro-op layout and operand-usage helpers for the ALU issue path.
package alu_pkg;

  localparam int NUM_PHYSICAL_REGS = 64;
  localparam int IW = $clog2(NUM_PHYSICAL_REGS);

  typedef enum logic [3:0] {
    ADD = 4'b0000,
    SUB = 4'b0001,
    AND = 4'b0010,
    OR  = 4'b0011,
    XOR = 4'b0100,
    NOT = 4'b0101,
    SHL = 4'b0110,
    MOV = 4'b0111,
    SHR = 4'b1000,
    RLS = 4'b1001,
    RRS = 4'b1010
  } alu_op_e;

  typedef struct packed {
    logic [3:0]    operation;
    logic [IW-1:0] operand_a;
    logic [IW-1:0] operand_b;
    logic [IW-1:0] operand_c;
    logic [IW-1:0] operand_d;
  } micro_op;

  function automatic logic uses_operand_b(alu_op_e op);
    case (op)
      NOT, MOV, RLS, RRS: return 1'b0;
      default:            return 1'b1;
    endcase
  endfunction

  // Codes past RRS carry no register operands at all.
  function automatic logic is_defined_op(logic [3:0] code);
    return code <= 4'(RRS);
  endfunction

endpackage

// File: rtl/alu_iq_storage.sv
// DEPTH-entry ring buffer of micro-ops with head read-out; clear resets pointers but not contents.
module alu_iq_storage
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  micro_op       push_data,
  input  logic          pop,
  output micro_op       head_data,
  output logic [PW-1:0] head_ptr,
  output logic [PW-1:0] tail_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  micro_op mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= tail_ptr + PW'(1);
      end
      if (pop) head_ptr <= head_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_data = mem[head_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/alu_issue_queue.sv
// In-order issue queue feeding the ALU: holds the head until its sources are ready,
// then presents it with alu_en until alu_done, chaining the next eligible op back-to-back.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NUM_PHYSICAL_REGS = alu_pkg::NUM_PHYSICAL_REGS,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_valid,
  input  micro_op                      disp_op,
  output logic                         disp_ready,
  input  logic [NUM_PHYSICAL_REGS-1:0] prf_ready,
  output logic                         alu_en,
  output micro_op                      alu_inst,
  input  logic                         alu_done,
  output logic [CW-1:0]                occupancy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  micro_op    head_data;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       head_elig;
  logic       issue_slot;

  // Ready is held low during reset so dispatch never sees a slot before the queue is live.
  assign disp_ready = !full && !flush && !rst;
  assign push       = disp_valid && disp_ready;

  always_comb begin
    head_elig = 1'b0;
    if (!empty) begin
      if (!is_defined_op(head_data.operation))
        head_elig = 1'b1;
      else
        head_elig = prf_ready[head_data.operand_a] &&
                    (!uses_operand_b(alu_op_e'(head_data.operation)) ||
                     prf_ready[head_data.operand_b]);
    end
  end

  assign issue_slot = (state == IDLE) || alu_done;
  assign pop        = issue_slot && head_elig && !flush;

  alu_iq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (disp_op),
    .pop       (pop),
    .head_data (head_data),
    .head_ptr  (),
    .tail_ptr  (),
    .count     (occupancy),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      alu_en   <= 1'b0;
      alu_inst <= '0;
    end else if (flush) begin
      state    <= IDLE;
      alu_en   <= 1'b0;
      alu_inst <= '0;
    end else if (pop) begin
      state    <= BUSY;
      alu_en   <= 1'b1;
      alu_inst <= head_data;
    end else if (state == BUSY && alu_done) begin
      state    <= IDLE;
      alu_en   <= 1'b0;
      alu_inst <= '0;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed scenarios followed by random traffic, all checked against a queue-based reference model.
module tb_alu_issue_queue;
  import alu_pkg::*;

  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          disp_valid;
  micro_op       disp_op;
  logic          disp_ready;
  logic [63:0]   prf_ready;
  logic          alu_en;
  micro_op       alu_inst;
  logic          alu_done;
  logic [3:0]    occupancy;

  int tests = 0;
  int fails = 0;

  micro_op mq[$];
  bit      m_busy;
  micro_op m_inst;
  micro_op fill_ops [DEPTH];

  alu_issue_queue #(.DEPTH(DEPTH), .NUM_PHYSICAL_REGS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .disp_valid (disp_valid),
    .disp_op    (disp_op),
    .disp_ready (disp_ready),
    .prf_ready  (prf_ready),
    .alu_en     (alu_en),
    .alu_inst   (alu_inst),
    .alu_done   (alu_done),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Eligibility straight from the opcode rules: unknown codes need nothing,
  // single-source ops need only A, everything else needs A and B.
  function automatic bit m_elig(micro_op o, logic [63:0] prf);
    int op;
    op = int'(o.operation);
    if (op > 10) return 1'b1;
    if (!prf[o.operand_a]) return 1'b0;
    if (op == 5 || op == 7 || op == 9 || op == 10) return 1'b1;
    return prf[o.operand_b];
  endfunction

  function automatic micro_op mk(int op, int a, int b);
    micro_op m;
    m           = '0;
    m.operation = 4'(op);
    m.operand_a = IW'(a);
    m.operand_b = IW'(b);
    m.operand_c = IW'($urandom);
    m.operand_d = IW'($urandom);
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_inst = '0;
  endtask

  // Called just after a rising edge with inputs already set; advances one cycle.
  task automatic cyc();
    bit can_push;
    #1;
    chk("disp_ready", disp_ready, (mq.size() < DEPTH) && !flush);
    @(posedge clk);
    if (flush) begin
      model_reset();
    end else begin
      can_push = mq.size() < DEPTH;
      if (!m_busy || alu_done) begin
        if (mq.size() > 0 && m_elig(mq[0], prf_ready)) begin
          m_inst = mq.pop_front();
          m_busy = 1'b1;
        end else if (m_busy) begin
          m_busy = 1'b0;
          m_inst = '0;
        end
      end
      if (disp_valid && can_push) mq.push_back(disp_op);
    end
    #1;
    chk("alu_en", alu_en, m_busy);
    chk("alu_inst", alu_inst, m_inst);
    chk("occupancy", occupancy, mq.size());
  endtask

  initial begin
    micro_op op_sub, op_mov, op_not, op_add;
    rst        = 1'b1;
    flush      = 1'b0;
    disp_valid = 1'b0;
    disp_op    = '0;
    prf_ready  = '1;
    alu_done   = 1'b1;
    model_reset();

    // Reset state
    #2;
    chk("rst_alu_en", alu_en, 0);
    chk("rst_alu_inst", alu_inst, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_disp_ready", disp_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single ADD, two-cycle issue latency
    op_add     = mk(0, 3, 4);
    disp_op    = op_add;
    disp_valid = 1'b1;
    cyc();
    chk("t1_no_bypass", alu_en, 0);
    chk("t1_occ1", occupancy, 1);
    disp_valid = 1'b0;
    cyc();
    chk("t1_alu_en", alu_en, 1);
    chk("t1_alu_inst", alu_inst, op_add);
    chk("t1_occ0", occupancy, 0);
    cyc();

    // 2: blocked head holds back younger MOV
    prf_ready[5] = 1'b0;
    op_sub     = mk(1, 5, 6);
    op_mov     = mk(7, 1, 0);
    disp_valid = 1'b1;
    disp_op    = op_sub;
    cyc();
    disp_op    = op_mov;
    cyc();
    disp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_blocked", alu_en, 0);
    end
    prf_ready[5] = 1'b1;
    cyc();
    chk("t2_sub_first", alu_inst, op_sub);
    cyc();
    chk("t2_mov_second", alu_inst, op_mov);
    cyc();

    // 3: NOT ignores operand_b readiness
    prf_ready    = '1;
    prf_ready[9] = 1'b0;
    op_not       = mk(5, 2, 9);
    disp_valid   = 1'b1;
    disp_op      = op_not;
    cyc();
    disp_valid = 1'b0;
    cyc();
    chk("t3_not_issued", alu_inst, op_not);
    cyc();

    // 4: fill all entries while blocked, then drain back-to-back
    prf_ready     = '1;
    prf_ready[10] = 1'b0;
    alu_done      = 1'b0;
    disp_valid    = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      fill_ops[i] = mk($urandom_range(0, 10), 10, 10);
      disp_op     = fill_ops[i];
      cyc();
    end
    chk("t4_full_occ", occupancy, DEPTH);
    disp_op = mk(0, 1, 1);
    chk("t4_full_ready", disp_ready, 0);
    cyc();
    disp_valid = 1'b0;
    prf_ready  = '1;
    alu_done   = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      chk("t4_order", alu_inst, fill_ops[i]);
    end
    chk("t4_drained", occupancy, 0);
    cyc();
    chk("t4_idle", alu_en, 0);

    // 5: flush with three queued and one in flight
    alu_done   = 1'b0;
    disp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      disp_op = mk(0, i, i + 1);
      cyc();
    end
    chk("t5_occ3", occupancy, 3);
    chk("t5_busy", alu_en, 1);
    flush   = 1'b1;
    disp_op = mk(1, 7, 7);
    cyc();
    chk("t5_flush_en", alu_en, 0);
    chk("t5_flush_occ", occupancy, 0);
    flush      = 1'b0;
    disp_valid = 1'b0;
    cyc();
    chk("t5_no_enq", occupancy, 0);

    // 6: asynchronous reset while BUSY
    disp_valid = 1'b1;
    disp_op    = mk(2, 1, 2);
    cyc();
    disp_op = mk(3, 3, 4);
    cyc();
    disp_valid = 1'b0;
    chk("t6_busy", alu_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_en", alu_en, 0);
    chk("t6_rst_inst", alu_inst, 0);
    chk("t6_rst_occ", occupancy, 0);
    chk("t6_rst_ready", disp_ready, 0);
    model_reset();
    @(posedge clk); #1;
    rst      = 1'b0;
    alu_done = 1'b1;
    op_add   = mk(0, 8, 9);
    disp_valid = 1'b1;
    disp_op    = op_add;
    cyc();
    disp_valid = 1'b0;
    cyc();
    chk("t6_resume", alu_inst, op_add);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      disp_valid = ($urandom_range(0, 3) != 0);
      disp_op    = mk($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 63));
      prf_ready  = ~({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      alu_done   = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
